// File: rtl/id_ex_stage_register_pkg.sv
// Constants shared by the decode control unit, the ID/EX register and the execute stage.
// Control-word bit positions are fixed here so all three agree on the packing.
package id_ex_stage_register_pkg;

   localparam logic [4:0] ZERO_REG = 5'd0;
   localparam int         ALUOP_W  = 4;

   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_MEMREAD   = 1;
   localparam int CTRL_MEMWRITE  = 2;
   localparam int CTRL_MEMTOREG  = 3;
   localparam int CTRL_ALUSRC    = 4;
   localparam int CTRL_BRANCH    = 5;
   localparam int CTRL_ALUOP_LSB = 6;
   localparam int CTRL_W         = CTRL_ALUOP_LSB + ALUOP_W;

endpackage

// File: rtl/id_ex_stage_register_ex_bypass_select.sv
// Write-back bypass mux for one operand; purely combinational. Built only with WB_BYPASS_EN.
// Register 0 is hardwired to zero, so a write-back targeting it never forwards.
`ifdef WB_BYPASS_EN
module ex_bypass_select
   import id_ex_stage_register_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [4:0]   i_src_reg,
   input  logic [N-1:0] i_read_data,
   input  logic         i_wb_regwrite,
   input  logic [4:0]   i_wb_reg,
   input  logic [N-1:0] i_wb_data,
   output logic [N-1:0] o_operand
);

   logic w_hit;

   assign w_hit     = i_wb_regwrite && (i_wb_reg != ZERO_REG) && (i_wb_reg == i_src_reg);
   assign o_operand = w_hit ? i_wb_data : i_read_data;

endmodule
`endif

// File: rtl/id_ex_stage_register.sv
// ID->EX pipeline register, 1-cycle latency; Flush > Stall > load, stall holds with optional operand refresh.
// Write-back bypass of both operands is enabled by defining WB_BYPASS_EN.
module id_ex_stage_register
   import id_ex_stage_register_pkg::*;
#(
   parameter int N       = 32,
   parameter int ALUOP_W = id_ex_stage_register_pkg::ALUOP_W,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Stall,
   input  logic               Flush,
   input  logic               ID_Valid,
   input  logic [4:0]         ReadRegister1,
   input  logic [4:0]         ReadRegister2,
   input  logic [N-1:0]       ReadData1,
   input  logic [N-1:0]       ReadData2,
   input  logic [4:0]         DestRegister,
   input  logic [N-1:0]       SignExtImm,
   input  logic [N-1:0]       PC4,
   input  logic               Ctrl_RegWrite,
   input  logic               Ctrl_MemRead,
   input  logic               Ctrl_MemWrite,
   input  logic               Ctrl_MemtoReg,
   input  logic               Ctrl_ALUSrc,
   input  logic               Ctrl_Branch,
   input  logic [ALUOP_W-1:0] Ctrl_ALUOp,
   input  logic               WB_RegWrite,
   input  logic [4:0]         WB_WriteRegister,
   input  logic [N-1:0]       WB_WriteData,
   output logic               EX_Valid,
   output logic [N-1:0]       EX_ReadData1,
   output logic [N-1:0]       EX_ReadData2,
   output logic [4:0]         EX_Rs,
   output logic [4:0]         EX_Rt,
   output logic [4:0]         EX_Rd,
   output logic [N-1:0]       EX_SignExtImm,
   output logic [N-1:0]       EX_PC4,
   output logic               EX_RegWrite,
   output logic               EX_MemRead,
   output logic               EX_MemWrite,
   output logic               EX_MemtoReg,
   output logic               EX_ALUSrc,
   output logic               EX_Branch,
   output logic [ALUOP_W-1:0] EX_ALUOp,
   output logic [CNT_W-1:0]   BubbleCount
);

   localparam int LP_CTRL_W = CTRL_ALUOP_LSB + ALUOP_W;

   logic                 r_valid;
   logic [N-1:0]         r_rd1, r_rd2, r_imm, r_pc4;
   logic [4:0]           r_rs, r_rt, r_rd;
   logic [LP_CTRL_W-1:0] r_ctrl;
   logic [CNT_W-1:0]     r_bubbles;

   logic                 w_load_bubble;
   logic [LP_CTRL_W-1:0] w_ctrl_in;
   logic [N-1:0]         w_op1, w_op2;

   assign w_load_bubble = Flush || (!Stall && !ID_Valid);

   always_comb begin
      w_ctrl_in                           = '0;
      w_ctrl_in[CTRL_REGWRITE]            = Ctrl_RegWrite;
      w_ctrl_in[CTRL_MEMREAD]             = Ctrl_MemRead;
      w_ctrl_in[CTRL_MEMWRITE]            = Ctrl_MemWrite;
      w_ctrl_in[CTRL_MEMTOREG]            = Ctrl_MemtoReg;
      w_ctrl_in[CTRL_ALUSRC]              = Ctrl_ALUSrc;
      w_ctrl_in[CTRL_BRANCH]              = Ctrl_Branch;
      w_ctrl_in[CTRL_ALUOP_LSB +: ALUOP_W] = Ctrl_ALUOp;
   end

`ifdef WB_BYPASS_EN
   // During a stall the same muxes re-check the held source registers against write-back.
   logic [4:0]   w_src1, w_src2;
   logic [N-1:0] w_dat1, w_dat2;

   assign w_src1 = Stall ? r_rs  : ReadRegister1;
   assign w_src2 = Stall ? r_rt  : ReadRegister2;
   assign w_dat1 = Stall ? r_rd1 : ReadData1;
   assign w_dat2 = Stall ? r_rd2 : ReadData2;

   ex_bypass_select #(.N(N)) u_byp1 (
      .i_src_reg     (w_src1),
      .i_read_data   (w_dat1),
      .i_wb_regwrite (WB_RegWrite),
      .i_wb_reg      (WB_WriteRegister),
      .i_wb_data     (WB_WriteData),
      .o_operand     (w_op1)
   );

   ex_bypass_select #(.N(N)) u_byp2 (
      .i_src_reg     (w_src2),
      .i_read_data   (w_dat2),
      .i_wb_regwrite (WB_RegWrite),
      .i_wb_reg      (WB_WriteRegister),
      .i_wb_data     (WB_WriteData),
      .o_operand     (w_op2)
   );
`else
   logic w_unused;

   assign w_op1    = Stall ? r_rd1 : ReadData1;
   assign w_op2    = Stall ? r_rd2 : ReadData2;
   assign w_unused = &{1'b0, WB_RegWrite, WB_WriteRegister, WB_WriteData};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid   <= 1'b0;
         r_rd1     <= '0;
         r_rd2     <= '0;
         r_rs      <= '0;
         r_rt      <= '0;
         r_rd      <= '0;
         r_imm     <= '0;
         r_pc4     <= '0;
         r_ctrl    <= '0;
         r_bubbles <= '0;
      end else if (w_load_bubble) begin
         r_valid <= 1'b0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
         r_rd    <= '0;
         r_imm   <= '0;
         r_pc4   <= '0;
         r_ctrl  <= '0;
         if (r_bubbles != {CNT_W{1'b1}})
            r_bubbles <= r_bubbles + CNT_W'(1);
      end else if (Stall) begin
         r_rd1 <= w_op1;
         r_rd2 <= w_op2;
      end else begin
         r_valid <= 1'b1;
         r_rd1   <= w_op1;
         r_rd2   <= w_op2;
         r_rs    <= ReadRegister1;
         r_rt    <= ReadRegister2;
         r_rd    <= DestRegister;
         r_imm   <= SignExtImm;
         r_pc4   <= PC4;
         r_ctrl  <= w_ctrl_in;
      end
   end

   assign EX_Valid      = r_valid;
   assign EX_ReadData1  = r_rd1;
   assign EX_ReadData2  = r_rd2;
   assign EX_Rs         = r_rs;
   assign EX_Rt         = r_rt;
   assign EX_Rd         = r_rd;
   assign EX_SignExtImm = r_imm;
   assign EX_PC4        = r_pc4;
   assign EX_RegWrite   = r_ctrl[CTRL_REGWRITE];
   assign EX_MemRead    = r_ctrl[CTRL_MEMREAD];
   assign EX_MemWrite   = r_ctrl[CTRL_MEMWRITE];
   assign EX_MemtoReg   = r_ctrl[CTRL_MEMTOREG];
   assign EX_ALUSrc     = r_ctrl[CTRL_ALUSRC];
   assign EX_Branch     = r_ctrl[CTRL_BRANCH];
   assign EX_ALUOp      = r_ctrl[CTRL_ALUOP_LSB +: ALUOP_W];
   assign BubbleCount   = r_bubbles;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Bench for id_ex_stage_register: directed scenarios plus random traffic checked against a
// rule-level reference model; counter width is reduced to 4 so saturation is reached quickly.
module tb_id_ex_stage_register;

   localparam int N     = 32;
   localparam int AW    = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          Stall, Flush, ID_Valid;
   logic [4:0]    ReadRegister1, ReadRegister2, DestRegister;
   logic [N-1:0]  ReadData1, ReadData2, SignExtImm, PC4;
   logic          Ctrl_RegWrite, Ctrl_MemRead, Ctrl_MemWrite, Ctrl_MemtoReg, Ctrl_ALUSrc, Ctrl_Branch;
   logic [AW-1:0] Ctrl_ALUOp;
   logic          WB_RegWrite;
   logic [4:0]    WB_WriteRegister;
   logic [N-1:0]  WB_WriteData;

   logic          EX_Valid;
   logic [N-1:0]  EX_ReadData1, EX_ReadData2, EX_SignExtImm, EX_PC4;
   logic [4:0]    EX_Rs, EX_Rt, EX_Rd;
   logic          EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_Branch;
   logic [AW-1:0] EX_ALUOp;
   logic [CNT_W-1:0] BubbleCount;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: the architectural contents of the EX slot.
   logic         m_valid;
   logic [N-1:0] m_rd1, m_rd2, m_imm, m_pc4;
   logic [4:0]   m_rs, m_rt, m_rd;
   logic [9:0]   m_ctrl;
   int           m_cnt;

   always #5 clk = ~clk;

   id_ex_stage_register #(.N(N), .ALUOP_W(AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ID_Valid(ID_Valid),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .DestRegister(DestRegister),
      .SignExtImm(SignExtImm), .PC4(PC4),
      .Ctrl_RegWrite(Ctrl_RegWrite), .Ctrl_MemRead(Ctrl_MemRead), .Ctrl_MemWrite(Ctrl_MemWrite),
      .Ctrl_MemtoReg(Ctrl_MemtoReg), .Ctrl_ALUSrc(Ctrl_ALUSrc), .Ctrl_Branch(Ctrl_Branch),
      .Ctrl_ALUOp(Ctrl_ALUOp),
      .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData),
      .EX_Valid(EX_Valid), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
      .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
      .EX_SignExtImm(EX_SignExtImm), .EX_PC4(EX_PC4),
      .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
      .EX_MemtoReg(EX_MemtoReg), .EX_ALUSrc(EX_ALUSrc), .EX_Branch(EX_Branch),
      .EX_ALUOp(EX_ALUOp), .BubbleCount(BubbleCount)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] fwd(input logic [4:0] src, input logic [N-1:0] dat);
`ifdef WB_BYPASS_EN
      if (WB_RegWrite && WB_WriteRegister != 5'd0 && WB_WriteRegister == src)
         return WB_WriteData;
`endif
      return dat;
   endfunction

   task automatic model_clear(input bit clr_cnt);
      m_valid = 1'b0;
      m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc4 = '0;
      m_rs = '0;  m_rt = '0;  m_rd = '0;  m_ctrl = '0;
      if (clr_cnt) m_cnt = 0;
   endtask

   // Next EX slot contents from the current inputs, evaluated just before the edge.
   task automatic model_step();
      if (Flush || (!Stall && !ID_Valid)) begin
         model_clear(1'b0);
         m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end else if (Stall) begin
         m_rd1 = fwd(m_rs, m_rd1);
         m_rd2 = fwd(m_rt, m_rd2);
      end else begin
         m_valid = 1'b1;
         m_rd1 = fwd(ReadRegister1, ReadData1);
         m_rd2 = fwd(ReadRegister2, ReadData2);
         m_rs = ReadRegister1; m_rt = ReadRegister2; m_rd = DestRegister;
         m_imm = SignExtImm; m_pc4 = PC4;
         m_ctrl = {Ctrl_ALUOp, Ctrl_Branch, Ctrl_ALUSrc, Ctrl_MemtoReg,
                   Ctrl_MemWrite, Ctrl_MemRead, Ctrl_RegWrite};
      end
   endtask

   task automatic check_all();
      chk("valid", 32'(EX_Valid), 32'(m_valid));
      chk("rd1",   EX_ReadData1, m_rd1);
      chk("rd2",   EX_ReadData2, m_rd2);
      chk("rs",    32'(EX_Rs), 32'(m_rs));
      chk("rt",    32'(EX_Rt), 32'(m_rt));
      chk("rd",    32'(EX_Rd), 32'(m_rd));
      chk("imm",   EX_SignExtImm, m_imm);
      chk("pc4",   EX_PC4, m_pc4);
      chk("ctrl",  32'({EX_ALUOp, EX_Branch, EX_ALUSrc, EX_MemtoReg,
                        EX_MemWrite, EX_MemRead, EX_RegWrite}), 32'(m_ctrl));
      chk("bubbles", 32'(BubbleCount), 32'(m_cnt));
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic rand_inputs();
      Stall = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      ID_Valid = ($urandom_range(0, 4) != 0);
      ReadRegister1 = 5'($urandom_range(0, 3));
      ReadRegister2 = 5'($urandom_range(0, 3));
      DestRegister = 5'($urandom);
      ReadData1 = $urandom; ReadData2 = $urandom;
      SignExtImm = $urandom; PC4 = $urandom;
      {Ctrl_ALUOp, Ctrl_Branch, Ctrl_ALUSrc, Ctrl_MemtoReg,
       Ctrl_MemWrite, Ctrl_MemRead, Ctrl_RegWrite} = 10'($urandom);
      WB_RegWrite = $urandom_range(0, 1) == 1;
      WB_WriteRegister = 5'($urandom_range(0, 3));
      WB_WriteData = $urandom;
   endtask

   task automatic plain_load();
      rand_inputs();
      Stall = 1'b0; Flush = 1'b0; ID_Valid = 1'b1; WB_RegWrite = 1'b0;
   endtask

   logic [N-1:0] exp_w;

   initial begin
      rand_inputs();
      reset = 1'b0;
      model_clear(1'b1);
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk) reset = 1'b1;

      // Basic capture
      plain_load();
      Ctrl_RegWrite = 1'b1; ReadData1 = 32'h0000_1234; ReadRegister1 = 5'd8;
      step();
      chk("t1_valid", 32'(EX_Valid), 32'd1);
      chk("t1_rd1", EX_ReadData1, 32'h0000_1234);
      chk("t1_regwrite", 32'(EX_RegWrite), 32'd1);

      // Bypass on load, then the register-0 exclusion
      plain_load();
      ReadRegister1 = 5'd9; ReadData1 = '0;
      WB_RegWrite = 1'b1; WB_WriteRegister = 5'd9; WB_WriteData = 32'hCAFE_0001;
      step();
`ifdef WB_BYPASS_EN
      exp_w = 32'hCAFE_0001;
`else
      exp_w = 32'h0;
`endif
      chk("t2_bypass", EX_ReadData1, exp_w);
      ReadRegister1 = 5'd0; WB_WriteRegister = 5'd0;
      step();
      chk("t2_reg0", EX_ReadData1, 32'h0);

      // Stall hold with write-back refresh of the held rt operand
      plain_load();
      ReadRegister2 = 5'd10; ReadData2 = 32'h11;
      step();
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         Stall = 1'b1; Flush = 1'b0;
         WB_RegWrite = 1'b1; WB_WriteRegister = 5'd10; WB_WriteData = 32'h22;
         step();
      end
`ifdef WB_BYPASS_EN
      exp_w = 32'h22;
`else
      exp_w = 32'h11;
`endif
      chk("t3_held_rd2", EX_ReadData2, exp_w);

      // Flush wins over Stall
      rand_inputs();
      Stall = 1'b1; Flush = 1'b1;
      step();
      chk("t4_valid", 32'(EX_Valid), 32'd0);

      for (int i = 0; i < 200; i++) begin
         rand_inputs();
         step();
      end

      // Reset asserted between edges while a valid instruction is held
      plain_load();
      step();
      Stall = 1'b1;
      step();
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_clear(1'b1);
      check_all();
      @(negedge clk);
      reset = 1'b1;
      plain_load();
      step();
      chk("t6_reload_valid", 32'(EX_Valid), 32'd1);

      for (int i = 0; i < 100; i++) begin
         rand_inputs();
         step();
      end

      // Counter saturation
      for (int i = 0; i < 20; i++) begin
         rand_inputs();
         Flush = 1'b1;
         step();
      end
      chk("t5_saturated", 32'(BubbleCount), 32'(CMAX));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
